// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder emulating a 64 KiB serial SRAM (READ 0x03 / WRITE 0x02) over a parallel synchronous memory port.
// Define SPI_RESP_BURST_EN to enable sequential burst access with address auto-increment.
module spi_mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int LEAD_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              err_cmd
);

`ifdef SPI_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int CNT_MAX = (ADDR_W > LEAD_BITS) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                                : ((LEAD_BITS > 8) ? LEAD_BITS : 8);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_CMD, S_ADDR, S_RD_LOAD, S_RD_SHIFT, S_WR_DATA, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_q, cs_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [7:0]             shreg;
  logic [7:0]             byte_in;
  logic                   is_read;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign byte_in   = {shreg[6:0], mosi_s};

  // Synchronisers clear to the idle bus levels so reset never fakes a CS or sclk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  // NOTE: every register here uses non-blocking assignment, so RD_LOAD sees last cycle's mem_re, not this cycle's.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      is_read     <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_addr    <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      err_cmd     <= 1'b0;
    end else begin
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      err_cmd <= 1'b0;
      if (BURST && mem_we) mem_addr <= mem_addr + 1'b1;

      if (cs_rise) begin
        // The initiator drops CS on the edge that drives the final write bit.
        if (state == S_WR_DATA && bit_cnt == CNT_W'(7)) begin
          mem_wdata <= byte_in;
          mem_we    <= 1'b1;
        end
        state       <= S_IDLE;
        bit_cnt     <= '0;
        busy        <= 1'b0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (cs_fall) begin
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= (LEAD_BITS > 0) ? S_LEAD : S_CMD;
          end
          S_LEAD: if (sclk_rise) begin
            if (bit_cnt == CNT_W'(LEAD_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= S_CMD;
            end else bit_cnt <= bit_cnt + 1'b1;
          end
          S_CMD: if (sclk_rise) begin
            shreg <= byte_in;
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt <= '0;
              case (byte_in)
                8'h03:   begin is_read <= 1'b1; state <= S_ADDR; end
                8'h02:   begin is_read <= 1'b0; state <= S_ADDR; end
                default: begin err_cmd <= 1'b1; state <= S_IGNORE; end
              endcase
            end else bit_cnt <= bit_cnt + 1'b1;
          end
          S_ADDR: if (sclk_rise) begin
            mem_addr <= {mem_addr[ADDR_W-2:0], mosi_s};
            if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
              bit_cnt <= '0;
              if (is_read) begin
                mem_re <= 1'b1;
                state  <= S_RD_LOAD;
              end else state <= S_WR_DATA;
            end else bit_cnt <= bit_cnt + 1'b1;
          end
          S_RD_LOAD: if (!mem_re) begin
            shreg       <= mem_rdata;
            spi_miso    <= mem_rdata[7];
            spi_miso_oe <= 1'b1;
            bit_cnt     <= '0;
            state       <= S_RD_SHIFT;
          end
          // Bits are counted on rises; a fall before the first rise belongs to the address phase.
          S_RD_SHIFT: begin
            if (sclk_rise) bit_cnt <= bit_cnt + 1'b1;
            else if (sclk_fall && bit_cnt != '0) begin
              if (bit_cnt == CNT_W'(8)) begin
                if (BURST) begin
                  mem_addr <= mem_addr + 1'b1;
                  mem_re   <= 1'b1;
                  state    <= S_RD_LOAD;
                end else begin
                  spi_miso    <= 1'b0;
                  spi_miso_oe <= 1'b0;
                  state       <= S_IGNORE;
                end
              end else begin
                shreg    <= {shreg[6:0], 1'b0};
                spi_miso <= shreg[6];
              end
            end
          end
          S_WR_DATA: if (sclk_rise) begin
            shreg <= byte_in;
            if (bit_cnt == CNT_W'(7)) begin
              mem_wdata <= byte_in;
              mem_we    <= 1'b1;
              bit_cnt   <= '0;
              if (!BURST) state <= S_IGNORE;
            end else bit_cnt <= bit_cnt + 1'b1;
          end
          S_IGNORE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench for spi_mem_responder: drives an SPI initiator, models the backing memory, compares against a byte-level reference.
module tb_spi_mem_responder;

`ifdef SPI_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem_wdata;
  logic        busy, err_cmd;

  always #5 clk = ~clk;

  spi_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .err_cmd    (err_cmd)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h96;
  endfunction

  // Environment memory seen by the DUT; only the monitor process writes it.
  logic [7:0]  env_mem [65536];
  bit          env_wr  [65536];
  logic        poke_req = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;
  int          re_cnt = 0, we_cnt = 0, err_cnt = 0, overlap = 0;
  logic [15:0] re_addr_q [$];
  logic [23:0] wr_log [$];

  always @(posedge clk) begin
    if (poke_req) begin
      env_mem[poke_addr] = poke_data;
      env_wr[poke_addr]  = 1'b1;
    end
    if (mem_re) begin
      mem_rdata <= env_wr[mem_addr] ? env_mem[mem_addr] : init_val(mem_addr);
      re_cnt++;
      re_addr_q.push_back(mem_addr);
    end else mem_rdata <= 8'($urandom);
    if (mem_we) begin
      env_mem[mem_addr] = mem_wdata;
      env_wr[mem_addr]  = 1'b1;
      we_cnt++;
      wr_log.push_back({mem_addr, mem_wdata});
    end
    if (err_cmd) err_cnt++;
    if (mem_re && mem_we) overlap++;
  end

  // Reference model: the byte contents the memory should hold after each transaction.
  logic [7:0] ref_mem [65536];
  bit         ref_wr  [65536];

  function automatic logic [7:0] ref_get(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic ref_put(input logic [15:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    ref_wr[a]  = 1'b1;
  endtask

  int half = 6;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    ref_put(a, d);
    poke_addr = a;
    poke_data = d;
    poke_req  = 1'b1;
    tick(1);
    poke_req  = 1'b0;
  endtask

  task automatic spi_bit(input logic b, output logic m, output logic oe);
    spi_mosi = b;
    tick(half);
    spi_sclk = 1'b1;
    m  = spi_miso;
    oe = spi_miso_oe;
    tick(half);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    logic m, o;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m, o);
      rx[i]  = m;
      oe_all &= o;
      oe_any |= o;
    end
  endtask

  task automatic spi_start();
    logic m, o;
    spi_cs_n = 1'b0;
    tick(half);
    spi_bit(1'b0, m, o);
  endtask

  task automatic spi_end();
    tick(half);
    spi_cs_n = 1'b1;
    tick(2 * half + 4);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] addr);
    logic [7:0] rx;
    logic all, any;
    spi_start();
    spi_byte(cmd, rx, all, any);
    spi_byte(addr[15:8], rx, all, any);
    spi_byte(addr[7:0], rx, all, any);
  endtask

  task automatic do_read(input logic [15:0] addr, input int n, input string tag);
    int re0, q0, nre;
    logic [7:0] rx;
    logic all, any;
    logic [15:0] a;
    re0 = re_cnt;
    q0  = re_addr_q.size();
    send_hdr(8'h03, addr);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      a = addr + 16'(i);
      spi_byte(8'h00, rx, all, any);
      if (i == 0 || BURST) begin
        check($sformatf("%s_byte%0d", tag, i), 32'(rx), 32'(ref_get(a)));
        check($sformatf("%s_oe%0d", tag, i), 32'(all), 32'd1);
      end else check($sformatf("%s_undriven%0d", tag, i), 32'(any), 32'd0);
    end
    spi_end();
    check({tag, "_idle"}, {30'd0, busy, spi_miso_oe}, 32'd0);
    nre = BURST ? n + 1 : 1;
    check({tag, "_re_count"}, 32'(re_cnt - re0), 32'(nre));
    for (int i = 0; i < nre; i++)
      if (re_addr_q.size() > q0 + i)
        check($sformatf("%s_re_addr%0d", tag, i), 32'(re_addr_q[q0+i]), 32'(addr + 16'(i)));
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] dw, input int n,
                          input bit late, input string tag);
    int w0, nw;
    logic [7:0] d, rx;
    logic all, any, m, o;
    w0 = wr_log.size();
    send_hdr(8'h02, addr);
    for (int i = 0; i < n; i++) begin
      d = dw[8*i +: 8];
      if (late && i == n - 1) begin
        for (int j = 7; j >= 1; j--) spi_bit(d[j], m, o);
        spi_mosi = d[0];
        spi_cs_n = 1'b1;
        tick(2 * half + 4);
      end else spi_byte(d, rx, all, any);
    end
    if (!late) spi_end();
    nw = BURST ? n : 1;
    for (int i = 0; i < nw; i++) ref_put(addr + 16'(i), dw[8*i +: 8]);
    check({tag, "_we_count"}, 32'(wr_log.size() - w0), 32'(nw));
    for (int i = 0; i < nw; i++)
      if (wr_log.size() > w0 + i)
        check($sformatf("%s_we%0d", tag, i), 32'(wr_log[w0+i]), {8'h00, addr + 16'(i), dw[8*i +: 8]});
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx;
    logic all, any, m, o;
    int err0, re0, we0;
    logic [31:0] dw;

    tick(3);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_oe", 32'(spi_miso_oe), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_cmd), 32'd0);
    rst_n = 1'b1;
    tick(5);

    poke(16'h1234, 8'hA5);
    do_read(16'h1234, 1, "read_a5");

    do_write(16'h00FF, 32'h3C, 1, 1'b1, "write_late");
    do_read(16'h00FF, 1, "readback_late");

    err0 = err_cnt; re0 = re_cnt; we0 = we_cnt;
    spi_start();
    spi_byte(8'h9F, rx, all, any);
    check("badcmd_oe_cmd", 32'(any), 32'd0);
    spi_byte(8'h12, rx, all, any);
    check("badcmd_oe_b1", 32'(any), 32'd0);
    spi_byte(8'h34, rx, all, any);
    check("badcmd_oe_b2", 32'(any), 32'd0);
    spi_end();
    check("badcmd_err", 32'(err_cnt - err0), 32'd1);
    check("badcmd_re", 32'(re_cnt - re0), 32'd0);
    check("badcmd_we", 32'(we_cnt - we0), 32'd0);
    do_read(16'h1234, 1, "after_badcmd");

    we0 = we_cnt;
    send_hdr(8'h02, 16'h0040);
    for (int j = 0; j < 4; j++) spi_bit(1'b1, m, o);
    spi_end();
    check("abort_we", 32'(we_cnt - we0), 32'd0);
    do_read(16'h0040, 1, "abort_readback");

    spi_start();
    spi_byte(8'h03, rx, all, any);
    spi_byte(8'h12, rx, all, any);
    for (int j = 0; j < 3; j++) spi_bit(1'b1, m, o);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {26'd0, spi_miso, spi_miso_oe, mem_re, mem_we, busy, err_cmd}, 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    check("midrst_wdata", 32'(mem_wdata), 32'd0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(4);
    do_read(16'h1234, 1, "after_reset");

    half = 8;
    poke(16'hFFFF, 8'h11);
    poke(16'h0000, 8'h22);
    do_read(16'hFFFF, 2, "burst_wrap");

    half = 6;
    do_write(16'h0010, 32'h5A, 1, 1'b0, "b2b_write");
    do_read(16'h0010, 1, "b2b_read");

    for (int t = 0; t < 16; t++) begin
      half = $urandom_range(6, 8);
      dw   = $urandom;
      if ($urandom_range(0, 1) == 0)
        do_read(16'($urandom), $urandom_range(1, 3), $sformatf("rnd%0d_rd", t));
      else
        do_write(16'($urandom), dw, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                 $sformatf("rnd%0d_wr", t));
    end

    check("re_we_overlap", 32'(overlap), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
